// File: rtl/reg_mem_arb_pkg.sv
// Shared definitions for the reg_mem arbiter.
// Contents: FSM state type, parameter limits checked at elaboration,
// and a ceiling-log2 helper used to size the grant index and wait counter.
package reg_mem_arb_pkg;

  localparam int MAX_NUM_REQ    = 8;
  localparam int MAX_RD_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  // Ceiling log2, never less than 1 so a width derived from it is always legal.
  function automatic int clog2(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req_i       - request vector, one bit per requester
//   ptr_i       - index of the requester with highest priority this cycle
//   grant_o     - one-hot winner (all zero when no request)
//   grant_idx_o - binary index of the winner (zero when no request)
// The pointer register is owned by the instantiating block.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  // Scan upward from the pointer, wrapping, and take the first active request.
  always_comb begin
    int  idx_s;
    logic found_s;
    grant_o     = '0;
    grant_idx_o = '0;
    found_s     = 1'b0;
    idx_s       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = (int'(ptr_i) + k) % NUM_REQ;
      if (!found_s && req_i[idx_s]) begin
        found_s        = 1'b1;
        grant_o[idx_s] = 1'b1;
        grant_idx_o    = IDX_W'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/reg_mem_arbiter.sv
// Round-robin arbiter sharing one single-port reg_mem between NUM_REQ requesters.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   req_valid/req_ready     - per-requester command handshake (ready is combinational)
//   req_we/req_addr/req_wdata - per-requester command, packed per requester
//   rsp_valid/rsp_rdata     - one-cycle response pulse to the winner, read data
//   mem_addr/mem_din/mem_wen/mem_dout - the reg_mem port, driven only from here
// One command is outstanding at a time: IDLE -> ISSUE -> (WAIT_RD) -> RESP -> IDLE.
module reg_mem_arbiter
  import reg_mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5,
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_BITS-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [ADDR_BITS-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_din,
  output logic                             mem_wen,
  input  logic [DATA_WIDTH-1:0]            mem_dout
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(MAX_RD_LATENCY + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  generate
    if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
      $error("reg_mem_arbiter: NUM_REQ out of range");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_rd_latency
      $error("reg_mem_arbiter: RD_LATENCY out of range");
    end
  endgenerate

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       gnt_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   we_q;
  logic [NUM_REQ-1:0]     rsp_valid_q;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q;
  logic [ADDR_BITS-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]  mem_din_q;
  logic                   mem_wen_q;
  logic [NUM_REQ-1:0]     win_s;
  logic [IDX_W-1:0]       win_idx_s;
  logic                   accept_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (win_s),
    .grant_idx_o (win_idx_s)
  );

  // A winner exists whenever anyone is valid, so accept needs no grant decode.
  assign accept_s = (state_q == IDLE) && (|req_valid);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end else begin
          state_d = WAIT_RD;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake output: only the round-robin winner sees ready, and only in IDLE.
  always_comb begin
    if (state_q == IDLE) begin
      req_ready = win_s;
    end else begin
      req_ready = '0;
    end
  end

  // Command capture, memory port drive, read wait and response registers.
  // mem_wen and rsp_valid are set one cycle ahead so they are high exactly in
  // ISSUE and RESP respectively.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_wen_q   <= 1'b0;
    end else begin
      mem_wen_q   <= 1'b0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            mem_addr_q <= req_addr[win_idx_s*ADDR_BITS +: ADDR_BITS];
            mem_din_q  <= req_wdata[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
            we_q       <= req_we[win_idx_s];
            mem_wen_q  <= req_we[win_idx_s];
            gnt_q      <= win_idx_s;
            ptr_q      <= (win_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_s + IDX_W'(1);
          end else begin
            ptr_q <= ptr_q;
          end
        end
        ISSUE: begin
          if (we_q) begin
            rsp_valid_q <= ONE_HOT0 << gnt_q;
          end else begin
            cnt_q <= CNT_W'(RD_LATENCY);
          end
        end
        WAIT_RD: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            rsp_rdata_q <= mem_dout;
            rsp_valid_q <= ONE_HOT0 << gnt_q;
          end else begin
            rsp_rdata_q <= rsp_rdata_q;
          end
        end
        RESP:    cnt_q <= cnt_q;
        default: cnt_q <= '0;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_wen   = mem_wen_q;

endmodule

// File: tb/tb_reg_mem_arbiter.sv
// Scoreboard bench: instance 0 uses RD_LATENCY=1, instance 1 uses RD_LATENCY=3,
// each backed by a behavioural reg_mem model with matching read latency.
module tb_reg_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       v_s  [2][2];
  logic       we_s [2][2];
  logic [4:0] ad_s [2][2];
  logic [7:0] wd_s [2][2];

  logic [1:0]  valid_w [2];
  logic [1:0]  we_w    [2];
  logic [9:0]  addr_w  [2];
  logic [15:0] wdata_w [2];
  logic [1:0]  ready_w [2];
  logic [1:0]  rv_w    [2];
  logic [7:0]  rdata_w [2];
  logic [4:0]  maddr_w [2];
  logic [7:0]  mdin_w  [2];
  logic        mwen_w  [2];
  logic [7:0]  mdout_w [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign valid_w[g] = {v_s[g][1], v_s[g][0]};
    assign we_w[g]    = {we_s[g][1], we_s[g][0]};
    assign addr_w[g]  = {ad_s[g][1], ad_s[g][0]};
    assign wdata_w[g] = {wd_s[g][1], wd_s[g][0]};
    reg_mem_arbiter #(
      .DATA_WIDTH (8),
      .ADDR_BITS  (5),
      .NUM_REQ    (2),
      .RD_LATENCY ((g == 0) ? 1 : 3)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (valid_w[g]),
      .req_ready (ready_w[g]),
      .req_we    (we_w[g]),
      .req_addr  (addr_w[g]),
      .req_wdata (wdata_w[g]),
      .rsp_valid (rv_w[g]),
      .rsp_rdata (rdata_w[g]),
      .mem_addr  (maddr_w[g]),
      .mem_din   (mdin_w[g]),
      .mem_wen   (mwen_w[g]),
      .mem_dout  (mdout_w[g])
    );
  end

  // Behavioural reg_mem: write on wen, read data emerges after the read latency.
  logic [7:0] mem  [2][32];
  logic [7:0] pipe [2][3];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mwen_w[i]) mem[i][maddr_w[i]] <= mdin_w[i];
      pipe[i][0] <= mem[i][maddr_w[i]];
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end
  assign mdout_w[0] = pipe[0][0];
  assign mdout_w[1] = pipe[1][2];

  typedef struct {
    int         inst;
    int         r;
    bit         rd;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nmis = 0;
  bit   wen_mon = 1'b0;
  int   wen_seen = 0;

  task automatic push_exp(input int inst, input int r, input bit rd, input logic [7:0] d, input int c);
    exp_t e;
    e.inst = inst; e.r = r; e.rd = rd; e.data = d; e.cyc = c;
    q.push_back(e);
  endtask

  // Present one command and hold it until accepted; optionally queue its response.
  task automatic drive(input int inst, input int r, input bit we, input logic [4:0] a,
                       input logic [7:0] wd, input logic [7:0] ex, input bit push);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    v_s[inst][r] = 1'b1; we_s[inst][r] = we; ad_s[inst][r] = a; wd_s[inst][r] = wd;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (ready_w[inst][r]) begin
        got = 1'b1;
        n = cyc;
      end
    end
    if (!got) begin
      nvec++; nmis++;
      $display("FAIL accept_timeout inst%0d req%0d: req_ready never high, required an accept", inst, r);
    end else if (push) begin
      push_exp(inst, r, !we, ex, n + 2 + (we ? 0 : ((inst == 0) ? 1 : 3)));
    end
    @(posedge clk); #1;
    v_s[inst][r] = 1'b0;
  endtask

  // Pops the scoreboard whenever any instance presents a response.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (wen_mon && mwen_w[1]) wen_seen++;
      if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          if (rv_w[i] != 2'b00) begin
            nvec++;
            if (q.size() == 0) begin
              nmis++;
              $display("FAIL rsp_unexpected inst%0d: rsp_valid=%b at cycle %0d, required no response", i, rv_w[i], cyc);
            end else begin
              e = q.pop_front();
              if (e.inst != i || rv_w[i] != (2'b01 << e.r) || (e.rd && rdata_w[i] !== e.data) || cyc != e.cyc) begin
                nmis++;
                $display("FAIL rsp inst%0d: got rsp_valid=%b rdata=%h cycle=%0d, required inst%0d rsp_valid=%b rdata=%h cycle=%0d",
                         i, rv_w[i], rdata_w[i], cyc, e.inst, 2'b01 << e.r, e.data, e.cyc);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (rv_w[i] !== 2'b00 || ready_w[i] !== 2'b00 || mwen_w[i] !== 1'b0 ||
          rdata_w[i] !== 8'h00 || maddr_w[i] !== 5'd0 || mdin_w[i] !== 8'h00) begin
        nmis++;
        $display("FAIL reset_%s inst%0d: rsp_valid=%b ready=%b wen=%b rdata=%h addr=%h din=%h, required all zero",
                 tag, i, rv_w[i], ready_w[i], mwen_w[i], rdata_w[i], maddr_w[i], mdin_w[i]);
      end
    end
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        v_s[i][j] = 1'b0; we_s[i][j] = 1'b0; ad_s[i][j] = 5'd0; wd_s[i][j] = 8'h00;
      end
    end
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Requester 0 alone: write then read back; top and bottom addresses.
    drive(0, 0, 1'b1, 5'd3,  8'hA5, 8'h00, 1'b1);
    drive(0, 0, 1'b0, 5'd3,  8'h00, 8'hA5, 1'b1);
    drive(0, 0, 1'b1, 5'd31, 8'h7F, 8'h00, 1'b1);
    drive(0, 0, 1'b1, 5'd0,  8'h01, 8'h00, 1'b1);
    drive(0, 0, 1'b0, 5'd31, 8'h00, 8'h7F, 1'b1);
    drive(0, 0, 1'b0, 5'd0,  8'h00, 8'h01, 1'b1);
    repeat (6) @(posedge clk); #1;

    // Fresh reset, then both requesters write in the same cycle: req0 wins first.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    c = cyc;
    push_exp(0, 0, 1'b0, 8'h00, c + 2);
    push_exp(0, 1, 1'b0, 8'h00, c + 5);
    fork
      drive(0, 0, 1'b1, 5'd5, 8'h11, 8'h00, 1'b0);
      drive(0, 1, 1'b1, 5'd6, 8'h22, 8'h00, 1'b0);
    join
    repeat (4) @(posedge clk); #1;

    // Both held valid for three reads each: grants alternate 0,1,0,1,0,1.
    c = cyc;
    push_exp(0, 0, 1'b1, 8'h11, c + 3);
    push_exp(0, 1, 1'b1, 8'h22, c + 7);
    push_exp(0, 0, 1'b1, 8'h7F, c + 11);
    push_exp(0, 1, 1'b1, 8'hA5, c + 15);
    push_exp(0, 0, 1'b1, 8'h01, c + 19);
    push_exp(0, 1, 1'b1, 8'h11, c + 23);
    fork
      begin
        drive(0, 0, 1'b0, 5'd5,  8'h00, 8'h00, 1'b0);
        drive(0, 0, 1'b0, 5'd31, 8'h00, 8'h00, 1'b0);
        drive(0, 0, 1'b0, 5'd0,  8'h00, 8'h00, 1'b0);
      end
      begin
        drive(0, 1, 1'b0, 5'd6, 8'h00, 8'h00, 1'b0);
        drive(0, 1, 1'b0, 5'd3, 8'h00, 8'h00, 1'b0);
        drive(0, 1, 1'b0, 5'd5, 8'h00, 8'h00, 1'b0);
      end
    join
    repeat (6) @(posedge clk); #1;

    // Reset during WAIT_RD of a req1 read: no response, outputs cleared.
    drive(0, 1, 1'b0, 5'd6, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    c = cyc;
    push_exp(0, 0, 1'b1, 8'hA5, c + 3);
    push_exp(0, 1, 1'b1, 8'h22, c + 7);
    fork
      drive(0, 0, 1'b0, 5'd3, 8'h00, 8'h00, 1'b0);
      drive(0, 1, 1'b0, 5'd6, 8'h00, 8'h00, 1'b0);
    join
    repeat (6) @(posedge clk); #1;

    // Read latency 3 instance: response at accept+5, mem_wen low for the read.
    drive(1, 0, 1'b1, 5'd10, 8'h3C, 8'h00, 1'b1);
    repeat (3) @(posedge clk); #1;
    wen_mon = 1'b1;
    drive(1, 0, 1'b0, 5'd10, 8'h00, 8'h3C, 1'b1);
    repeat (8) @(posedge clk); #1;
    wen_mon = 1'b0;
    nvec++;
    if (wen_seen != 0) begin
      nmis++;
      $display("FAIL lat3_wen: mem_wen high for %0d cycles during read, required 0", wen_seen);
    end

    nvec++;
    if (q.size() != 0) begin
      nmis++;
      $display("FAIL missing_rsp: %0d responses outstanding, required 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
